// File: rtl/vpifo_task_arbiter.sv
// Round-robin arbiter that turns per-tree push/pop requests into task words
// for a downstream task FIFO, tracking the logical occupancy of each tree.
module vpifo_task_arbiter #(
    parameter int unsigned PTW      = 16,
    parameter int unsigned MTW      = 16,
    parameter int unsigned TREE_NUM = 4,
    parameter int unsigned TREE_CAP = 1024,
    parameter int unsigned BUF_SIZE = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [TREE_NUM-1:0]                        i_push,
    input  logic [TREE_NUM-1:0]                        i_pop,
    input  logic [TREE_NUM*(PTW+MTW)-1:0]              i_push_data,
    output logic [TREE_NUM-1:0]                        o_ack,
    output logic                                       o_ack_is_push,
    input  logic [$clog2(BUF_SIZE):0]                  i_fifo_count,
    output logic                                       o_wr_en,
    output logic [PTW+MTW+$clog2(TREE_NUM):0]          o_task,
    output logic [TREE_NUM*$clog2(TREE_CAP+1)-1:0]     o_tree_cnt,
    output logic [TREE_NUM-1:0]                        o_tree_empty,
    output logic [TREE_NUM-1:0]                        o_tree_full
);

    localparam int unsigned TREE_NUM_BITS = $clog2(TREE_NUM);
    localparam int unsigned CNT_W         = $clog2(TREE_CAP + 1);
    localparam int unsigned BUF_WIDTH     = $clog2(BUF_SIZE);
    localparam int unsigned DW            = PTW + MTW;
    localparam int unsigned SUM_W         = BUF_WIDTH + 2;

    logic [TREE_NUM_BITS-1:0] rr_ptr;
    logic [CNT_W-1:0]         cnt [TREE_NUM];
    logic [DW-1:0]            push_data [TREE_NUM];
    logic [TREE_NUM-1:0]      pop_elig;
    logic [TREE_NUM-1:0]      push_elig;
    logic                     permit;
    logic                     gnt_vld;
    logic [TREE_NUM_BITS-1:0] gnt_idx;
    logic                     gnt_push;
    logic [TREE_NUM_BITS-1:0] cand_idx;
    logic [DW-1:0]            task_data;

    // Per-tree eligibility: pops need a non-empty tree, pushes a non-full one.
    always_comb begin
        for (int t = 0; t < TREE_NUM; t++) begin
            push_data[t] = i_push_data[t*DW +: DW];
            pop_elig[t]  = i_pop[t]  && (cnt[t] != '0);
            push_elig[t] = i_push[t] && (cnt[t] != CNT_W'(TREE_CAP));
        end
    end

    // Grant only if the FIFO still has room once the in-flight write lands.
    assign permit = (SUM_W'(i_fifo_count) + SUM_W'(o_wr_en)) < SUM_W'(BUF_SIZE);

    // Round-robin search from rr_ptr; pop wins over push within a tree.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_push = 1'b0;
        cand_idx = '0;
        if (permit && !rst) begin
            for (int i = 0; i < TREE_NUM; i++) begin
                cand_idx = rr_ptr + TREE_NUM_BITS'(i);
                if (!gnt_vld && (pop_elig[cand_idx] || push_elig[cand_idx])) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = cand_idx;
                    gnt_push = !pop_elig[cand_idx];
                end
            end
        end
    end

    // One-hot acknowledge in the grant cycle.
    always_comb begin
        o_ack         = '0;
        o_ack_is_push = gnt_vld && gnt_push;
        if (gnt_vld) begin
            o_ack[gnt_idx] = 1'b1;
        end
    end

    // Payload carried into the task word; pops carry zero data.
    always_comb begin
        task_data = '0;
        if (gnt_push) begin
            task_data = push_data[gnt_idx];
        end
    end

    // Task register, round-robin pointer and per-tree occupancy counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wr_en <= 1'b0;
            o_task  <= '0;
            rr_ptr  <= '0;
            for (int t = 0; t < TREE_NUM; t++) begin
                cnt[t] <= '0;
            end
        end else begin
            o_wr_en <= gnt_vld;
            if (gnt_vld) begin
                o_task  <= {gnt_push, gnt_idx, task_data};
                rr_ptr  <= gnt_idx + TREE_NUM_BITS'(1);
                if (gnt_push) begin
                    cnt[gnt_idx] <= cnt[gnt_idx] + CNT_W'(1);
                end else begin
                    cnt[gnt_idx] <= cnt[gnt_idx] - CNT_W'(1);
                end
            end else begin
                o_task <= '0;
            end
        end
    end

    // Flattened occupancy and status flags.
    for (genvar t = 0; t < TREE_NUM; t++) begin : g_tree
        assign o_tree_cnt[t*CNT_W +: CNT_W] = cnt[t];
        assign o_tree_empty[t] = (cnt[t] == '0);
        assign o_tree_full[t]  = (cnt[t] == CNT_W'(TREE_CAP));
    end

endmodule

// File: tb/tb_vpifo_task_arbiter.sv
// Scoreboard bench for vpifo_task_arbiter: a driver applies directed and
// random requests, a reference model queues the expected responses, and
// two monitors compare the acknowledge and the registered task/counters.
module tb_vpifo_task_arbiter;

    localparam int TN  = 4;
    localparam int PTW = 16;
    localparam int MTW = 16;
    localparam int CAP = 2;
    localparam int BUF = 8;
    localparam int DW  = PTW + MTW;
    localparam int TNB = $clog2(TN);
    localparam int CW  = $clog2(CAP + 1);
    localparam int BW  = $clog2(BUF);
    localparam int TW  = DW + TNB + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [TN-1:0]      i_push;
    logic [TN-1:0]      i_pop;
    logic [TN*DW-1:0]   i_push_data;
    logic [TN-1:0]      o_ack;
    logic               o_ack_is_push;
    logic [BW:0]        i_fifo_count;
    logic               o_wr_en;
    logic [TW-1:0]      o_task;
    logic [TN*CW-1:0]   o_tree_cnt;
    logic [TN-1:0]      o_tree_empty;
    logic [TN-1:0]      o_tree_full;

    vpifo_task_arbiter #(
        .PTW(PTW), .MTW(MTW), .TREE_NUM(TN), .TREE_CAP(CAP), .BUF_SIZE(BUF)
    ) dut (
        .clk(clk), .rst(rst),
        .i_push(i_push), .i_pop(i_pop), .i_push_data(i_push_data),
        .o_ack(o_ack), .o_ack_is_push(o_ack_is_push),
        .i_fifo_count(i_fifo_count),
        .o_wr_en(o_wr_en), .o_task(o_task),
        .o_tree_cnt(o_tree_cnt), .o_tree_empty(o_tree_empty), .o_tree_full(o_tree_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TN-1:0] ack;
        logic          is_push;
    } ack_exp_t;

    typedef struct {
        logic             wr;
        logic [TW-1:0]    task_w;
        logic [TN*CW-1:0] cnt;
        logic [TN-1:0]    empty;
        logic [TN-1:0]    full;
    } out_exp_t;

    ack_exp_t ack_q[$];
    out_exp_t out_q[$];
    ack_exp_t ea;
    out_exp_t eo;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: occupancy per tree, next-first tree, pending write.
    int       m_cnt [TN];
    int       m_rr;
    bit       m_wr;
    bit       mon_en;
    logic [DW-1:0] pdata [TN];
    int       last_g;
    bit       last_push;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic reset_model();
        for (int t = 0; t < TN; t++) m_cnt[t] = 0;
        m_rr = 0;
        m_wr = 1'b0;
        ack_q.delete();
        out_q.delete();
    endtask

    // One cycle of stimulus plus the model's prediction for it.
    task automatic step(input logic [TN-1:0] push, input logic [TN-1:0] pop, input int fcnt);
        ack_exp_t      ae;
        out_exp_t      oe;
        int            g;
        int            tt;
        bit            isp;
        logic [DW-1:0] dd;
        @(posedge clk);
        #2;
        i_push       = push;
        i_pop        = pop;
        i_fifo_count = (BW+1)'(fcnt);
        for (int t = 0; t < TN; t++) i_push_data[t*DW +: DW] = pdata[t];
        g   = -1;
        isp = 1'b0;
        if (fcnt + (m_wr ? 1 : 0) < BUF) begin
            for (int k = 0; k < TN; k++) begin
                tt = (m_rr + k) % TN;
                if (g < 0) begin
                    if (pop[tt] && m_cnt[tt] > 0) begin
                        g = tt; isp = 1'b0;
                    end else if (push[tt] && m_cnt[tt] < CAP) begin
                        g = tt; isp = 1'b1;
                    end
                end
            end
        end
        ae.ack     = '0;
        ae.is_push = isp;
        dd         = '0;
        if (g >= 0) begin
            ae.ack[g] = 1'b1;
            if (isp) begin
                dd = pdata[g];
                m_cnt[g] = m_cnt[g] + 1;
            end else begin
                m_cnt[g] = m_cnt[g] - 1;
            end
            m_rr = (g + 1) % TN;
        end
        m_wr      = (g >= 0);
        oe.wr     = (g >= 0);
        oe.task_w = (g >= 0) ? {isp, TNB'(g), dd} : '0;
        for (int t = 0; t < TN; t++) begin
            oe.cnt[t*CW +: CW] = CW'(m_cnt[t]);
            oe.empty[t]        = (m_cnt[t] == 0);
            oe.full[t]         = (m_cnt[t] == CAP);
        end
        ack_q.push_back(ae);
        out_q.push_back(oe);
        last_g    = g;
        last_push = isp;
    endtask

    // Combinational acknowledge, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && ack_q.size() > 0) begin
            ea = ack_q.pop_front();
            chk("o_ack", 64'(o_ack), 64'(ea.ack));
            if (ea.ack != '0) chk("o_ack_is_push", 64'(o_ack_is_push), 64'(ea.is_push));
        end
    end

    // Registered task word and counters, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (mon_en && out_q.size() > 0) begin
            eo = out_q.pop_front();
            chk("o_wr_en", 64'(o_wr_en), 64'(eo.wr));
            chk("o_task", 64'(o_task), 64'(eo.task_w));
            chk("o_tree_cnt", 64'(o_tree_cnt), 64'(eo.cnt));
            chk("o_tree_empty", 64'(o_tree_empty), 64'(eo.empty));
            chk("o_tree_full", 64'(o_tree_full), 64'(eo.full));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    logic [TN-1:0] rp;
    logic [TN-1:0] rq;
    logic [TN-1:0] skp;
    logic [TN-1:0] skq;
    int            r;
    int            f;

    initial begin
        rst          = 1'b1;
        i_push       = '0;
        i_pop        = '0;
        i_push_data  = '0;
        i_fifo_count = '0;
        mon_en       = 1'b0;
        reset_model();
        for (int t = 0; t < TN; t++) pdata[t] = '0;
        repeat (3) @(posedge clk);
        #1;
        i_push = '1;
        #1;
        chk("rst_o_ack", 64'(o_ack), 64'(0));
        chk("rst_o_wr_en", 64'(o_wr_en), 64'(0));
        chk("rst_o_task", 64'(o_task), 64'(0));
        chk("rst_o_tree_cnt", 64'(o_tree_cnt), 64'(0));
        chk("rst_o_tree_empty", 64'(o_tree_empty), 64'(4'hF));
        chk("rst_o_tree_full", 64'(o_tree_full), 64'(0));
        i_push = '0;
        @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single push to tree 0.
        pdata[0] = 32'hABCD1234;
        step(4'b0001, 4'b0000, 0);
        step(4'b0000, 4'b0000, 0);

        // Pop on an empty tree waits, then follows a push to that tree.
        repeat (10) step(4'b0000, 4'b0010, 0);
        pdata[1] = 32'h1111_2222;
        step(4'b0010, 4'b0010, 0);
        step(4'b0000, 4'b0010, 0);
        step(4'b0000, 4'b0000, 0);

        // Push and pop together on a non-empty tree: pop first.
        pdata[2] = 32'h2222_3333;
        step(4'b0100, 4'b0000, 0);
        pdata[2] = 32'h4444_5555;
        step(4'b0100, 4'b0100, 0);
        step(4'b0100, 4'b0000, 0);
        step(4'b0000, 4'b0000, 0);

        // FIFO nearly full with a write in flight blocks the grant.
        pdata[3] = 32'h3333_4444;
        step(4'b1000, 4'b0000, 6);
        step(4'b0000, 4'b0001, 7);
        step(4'b0000, 4'b0001, 6);
        step(4'b0000, 4'b0000, 8);

        // Reset while a task is registered.
        pdata[2] = 32'h5555_6666;
        step(4'b0100, 4'b0000, 0);
        @(posedge clk);
        #3;
        rst    = 1'b1;
        mon_en = 1'b0;
        reset_model();
        i_push = '1;
        #1;
        chk("midrst_o_wr_en", 64'(o_wr_en), 64'(0));
        chk("midrst_o_task", 64'(o_task), 64'(0));
        chk("midrst_o_ack", 64'(o_ack), 64'(0));
        chk("midrst_o_tree_cnt", 64'(o_tree_cnt), 64'(0));
        chk("midrst_o_tree_empty", 64'(o_tree_empty), 64'(4'hF));
        i_push = '0;
        i_pop  = '0;
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        // All trees push continuously until every tree is full.
        for (int c = 0; c < 12; c++) begin
            for (int t = 0; t < TN; t++) pdata[t] = $urandom;
            step(4'b1111, 4'b0000, 0);
        end
        // All trees pop continuously until every tree is empty.
        for (int c = 0; c < 10; c++) step(4'b0000, 4'b1111, 0);

        // Randomized traffic with held requests and FIFO backpressure.
        rp  = '0;
        rq  = '0;
        skp = '0;
        skq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int t = 0; t < TN; t++) begin
                if (skp[t]) skp[t] = 1'b0;
                else if (!rp[t] && ($urandom % 3 == 0)) begin
                    rp[t]    = 1'b1;
                    pdata[t] = $urandom;
                end
                if (skq[t]) skq[t] = 1'b0;
                else if (!rq[t] && ($urandom % 4 == 0)) rq[t] = 1'b1;
            end
            r = $urandom % 8;
            f = (r < 5) ? $urandom_range(0, 5) : $urandom_range(6, 8);
            step(rp, rq, f);
            if (last_g >= 0) begin
                if (last_push) begin
                    rp[last_g]  = 1'b0;
                    skp[last_g] = 1'b1;
                end else begin
                    rq[last_g]  = 1'b0;
                    skq[last_g] = 1'b1;
                end
            end
        end

        step(4'b0000, 4'b0000, 0);
        step(4'b0000, 4'b0000, 0);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
